// File: rtl/load_store_unit.sv
// MEM-stage load/store controller in front of a word-wide, byte-lane data memory.
// Handles alignment checks, lane enables, store replication and load extension.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  input  logic [31:0] mem_read_data,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_data
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam logic [3:0] LAST = 4'(READ_LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  count;
  logic        write_q;
  logic        signed_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [3:0]  enable_q;
  logic [31:0] load_q;

  logic        accept;
  logic        misaligned;
  logic [3:0]  enable;
  logic [31:0] wdata_rep;
  logic [31:0] shifted;
  logic [31:0] extended;

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    enable     = 4'b0000;
    wdata_rep  = req_wdata;
    unique case (req_size)
      2'b00: begin
        enable    = 4'b0001 << req_addr[1:0];
        wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = req_addr[0];
        enable     = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = |req_addr[1:0];
        enable     = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // halves are aligned, so 8*lane equals 16*addr[1] for them
  always_comb begin
    shifted  = mem_read_data >> {lane_q, 3'b000};
    extended = shifted;
    unique case (size_q)
      2'b00:   extended = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   extended = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      count          <= 4'd0;
      write_q        <= 1'b0;
      signed_q       <= 1'b0;
      size_q         <= 2'b00;
      lane_q         <= 2'b00;
      enable_q       <= 4'b0000;
      load_q         <= 32'd0;
      mem_address    <= 32'd0;
      mem_write_data <= 32'd0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            size_q   <= req_size;
            lane_q   <= req_addr[1:0];
            count    <= 4'd0;
            load_q   <= 32'd0;
            if (misaligned) begin
              state <= ERROR;
            end else begin
              state       <= ACCESS;
              enable_q    <= enable;
              mem_address <= {2'b00, req_addr[31:2]};
              if (req_write) mem_write_data <= wdata_rep;
            end
          end
        end
        ACCESS: begin
          if (write_q) begin
            state <= DONE;
          end else if (count == LAST) begin
            load_q <= extended;
            state  <= DONE;
          end else begin
            count <= count + 4'd1;
          end
        end
        DONE:    state <= IDLE;
        ERROR:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // gating with reset drops a store whose edge coincides with reset
  assign mem_write  = (state == ACCESS && write_q && !reset) ? enable_q : 4'b0000;
  assign mem_read   = (state == ACCESS) && !write_q && !reset;
  assign resp_valid = (state == DONE) || (state == ERROR);
  assign resp_err   = (state == ERROR);
  assign resp_data  = (state == DONE && !write_q) ? load_q : 32'd0;

endmodule
